// File: rtl/vector_sweeper_pkg.sv
// rtl/vector_sweeper_pkg.sv - shared constants and FSM encoding for vector_sweeper
package vector_sweeper_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Truth table of y = (~b & ~c) | (a & ~b), bit index {a,b,c}
    localparam logic [7:0] DEFAULT_EXPECTED = 8'h31;

    // Width of the {a,b,c} stimulus vector
    localparam int VEC_W = 3;

endpackage

// File: rtl/vector_sweeper_if.sv
// rtl/vector_sweeper_if.sv - stimulus/result bundle between sweeper and its environment
//
// Signals:
//   start      - begin a sweep (honoured in IDLE/DONE only)
//   a, b, c    - stimulus vector driven to the function under test
//   y          - result returned by the function under test
//   busy, done - sweep running / sweep finished
//   pass       - no mismatches in the last sweep (valid with done)
//   err_cnt    - mismatch count 0..8
//   fail_valid - a mismatch has been recorded this sweep
//   first_fail - {a,b,c} of the first mismatch
// Modports: master = sweeper side, slave = environment side.
interface vector_sweeper_if;
    import vector_sweeper_pkg::*;

    logic             start;
    logic             a;
    logic             b;
    logic             c;
    logic             y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [3:0]       err_cnt;
    logic             fail_valid;
    logic [VEC_W-1:0] first_fail;

    modport master (
        input  start, y,
        output a, b, c, busy, done, pass, err_cnt, fail_valid, first_fail
    );

    modport slave (
        output start, y,
        input  a, b, c, busy, done, pass, err_cnt, fail_valid, first_fail
    );

endinterface

// File: rtl/vector_sweeper_dwell_timer.sv
// rtl/vector_sweeper_dwell_timer.sv - hold-time counter with one-cycle tick at DWELL-1
//
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   clr   - synchronous clear to 0 (wins over en)
//   en    - count enable
//   tick  - high for the cycle in which the count equals DWELL-1 while enabled
module dwell_timer #(
    parameter int unsigned DWELL = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // Minimal width able to hold DWELL-1, never less than one bit
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/vector_sweeper.sv
// rtl/vector_sweeper.sv - walks {a,b,c} 000..111, checks y against a truth table
//
// Parameters:
//   DWELL    - cycles each vector is held (1..255)
//   EXPECTED - expected y per vector, bit index {a,b,c}
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - vector_sweeper_if.master (start, a/b/c, y, status and results)
module vector_sweeper
    import vector_sweeper_pkg::*;
#(
    parameter int unsigned DWELL    = 10,
    parameter logic [7:0]  EXPECTED = DEFAULT_EXPECTED
) (
    input logic              clk,
    input logic              rst_n,
    vector_sweeper_if.master bus
);

    state_t           state;
    state_t           state_nxt;
    logic [VEC_W-1:0] idx;
    logic [3:0]       err_q;
    logic [3:0]       err_nxt;
    logic             fail_valid_q;
    logic [VEC_W-1:0] first_fail_q;
    logic             pass_q;
    logic             tick;
    logic             start_ok;
    logic             last_vec;
    logic             mismatch;
    logic             cmp_edge;

    // start only counts outside RUN, so a running sweep cannot be restarted
    assign start_ok = bus.start && (state != ST_RUN);
    assign cmp_edge = (state == ST_RUN) && tick;
    assign last_vec = (idx == VEC_W'(7));
    assign mismatch = (bus.y != EXPECTED[idx]);
    // Count including the compare happening on this edge; feeds pass on the last vector
    assign err_nxt  = err_q + {3'b000, mismatch};

    dwell_timer #(
        .DWELL(DWELL)
    ) u_dwell_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (start_ok),
        .en   (state == ST_RUN),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (tick && last_vec) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
        end else if (start_ok) begin
            idx          <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
        end else if (cmp_edge) begin
            err_q <= err_nxt;
            if (mismatch && !fail_valid_q) begin
                fail_valid_q <= 1'b1;
                first_fail_q <= idx;
            end
            if (last_vec) begin
                pass_q <= (err_nxt == 4'd0);
                idx    <= '0;
            end else begin
                idx <= idx + VEC_W'(1);
            end
        end
    end

    // Vector is only driven while running; IDLE and DONE present 000
    assign {bus.a, bus.b, bus.c} = (state == ST_RUN) ? idx : '0;
    assign bus.busy       = (state == ST_RUN);
    assign bus.done       = (state == ST_DONE);
    assign bus.pass       = pass_q;
    assign bus.err_cnt    = err_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.first_fail = first_fail_q;

endmodule
